// File: rtl/booth_pp_accumulator_if.sv
// Partial-product stream in, signed product out, plus flush and debug group index.
// The slave modport is the accumulator's view; the master modport is the producer/consumer side.
interface booth_pp_accumulator_if #(
  parameter int N = 4
);
  localparam int G  = N / 2;
  localparam int GW = $clog2(G) + 1;

  logic              flush;
  logic              pp_valid;
  logic              pp_ready;
  logic [N+1:0]      pp;
  logic              out_valid;
  logic              out_ready;
  logic [2*N-1:0]    product;
  logic [GW-1:0]     group_idx;

  modport slave (
    input  flush, pp_valid, pp, out_ready,
    output pp_ready, out_valid, product, group_idx
  );

  modport master (
    output flush, pp_valid, pp, out_ready,
    input  pp_ready, out_valid, product, group_idx
  );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Reduces a radix-4 Booth partial-product stream (LSB group first) to a signed 2N-bit product.
// Latency: out_valid rises on the edge accepting the last group; one product per G+1 cycles at best.
// Backpressure: pp_ready is low while a finished product waits on out_ready.
module booth_pp_accumulator #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_pp_accumulator_if.slave bus
);
  localparam int G  = N / 2;
  localparam int GW = $clog2(G) + 1;
  localparam int W  = 2 * N;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t         state;
  logic [W-1:0]   acc;
  logic [GW-1:0]  gidx;
  logic [W-1:0]   pp_ext;
  logic [W-1:0]   acc_sum;
  logic           xfer;

  assign xfer    = bus.pp_valid && bus.pp_ready;
  assign pp_ext  = {{(W-N-2){bus.pp[N+1]}}, bus.pp};
  // Group i carries weight 4^i, i.e. a left shift by 2*i.
  assign acc_sum = acc + (pp_ext << {gidx, 1'b0});

  assign bus.group_idx = gidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      gidx          <= '0;
      bus.product   <= '0;
      bus.out_valid <= 1'b0;
      bus.pp_ready  <= 1'b0;
    end else if (bus.flush) begin
      state         <= IDLE;
      acc           <= '0;
      gidx          <= '0;
      bus.out_valid <= 1'b0;
      bus.pp_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.pp_ready <= 1'b1;
          if (xfer) begin
            acc   <= pp_ext;
            gidx  <= GW'(1);
            state <= ACC;
          end
        end
        ACC: begin
          bus.pp_ready <= 1'b1;
          if (xfer) begin
            acc  <= acc_sum;
            gidx <= gidx + GW'(1);
            if (gidx == GW'(G - 1)) begin
              bus.product   <= acc_sum;
              bus.out_valid <= 1'b1;
              bus.pp_ready  <= 1'b0;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.pp_ready  <= 1'b1;
            acc           <= '0;
            gidx          <= '0;
            state         <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          acc          <= '0;
          gidx         <= '0;
          bus.pp_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator at N=4: a vector table of Booth streams plus
// hand-written sequences for backpressure, input gaps, flush and asynchronous reset.
module tb_booth_pp_accumulator;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  booth_pp_accumulator_if #(.N(4)) bus ();

  booth_pp_accumulator #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] pp0;
    logic [5:0] pp1;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] v);
    int n;
    n = 0;
    while (bus.pp_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.pp_ready !== 1'b1) chk("send_ready_timeout", {15'd0, bus.pp_ready}, 16'd1);
    bus.pp       = v;
    bus.pp_valid = 1'b1;
    step();
    bus.pp_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [5:0] a, input logic [5:0] b, input logic [7:0] e);
    vec_t v;
    v.pp0 = a;
    v.pp1 = b;
    v.exp = e;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass        = 0;
    n_total       = 0;
    bus.flush     = 1'b0;
    bus.pp_valid  = 1'b0;
    bus.pp        = '0;
    bus.out_ready = 1'b0;

    // Booth group pp values for N=4, computed by hand: pp_i = digit_i * A.
    vecs[0] = mk(6'h06, 6'h3D, 8'hFA); // -3 *  2 = -6
    vecs[1] = mk(6'h00, 6'h32, 8'hC8); //  7 * -8 = -56
    vecs[2] = mk(6'h00, 6'h10, 8'h40); // -8 * -8 = +64
    vecs[3] = mk(6'h3B, 6'h05, 8'h0F); //  5 *  3 = 15
    vecs[4] = mk(6'h07, 6'h32, 8'hCF); // -7 *  7 = -49
    vecs[5] = mk(6'h39, 6'h0E, 8'h31); //  7 *  7 = 49
    vecs[6] = mk(6'h08, 6'h30, 8'hC8); // -8 *  7 = -56
    vecs[7] = mk(6'h3A, 6'h3A, 8'hE2); //  6 * -5 = -30
    vecs[8] = mk(6'h00, 6'h00, 8'h00); //  0 *  x = 0
    vecs[9] = mk(6'h01, 6'h00, 8'h01); // -1 * -1 = 1

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("reset_pp_ready",  {15'd0, bus.pp_ready},  16'd0);
    chk("reset_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("reset_product",   {8'd0, bus.product},    16'd0);
    chk("reset_group_idx", {14'd0, bus.group_idx}, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("release_pp_ready_before_edge", {15'd0, bus.pp_ready}, 16'd0);
    step();
    chk("release_pp_ready_after_edge", {15'd0, bus.pp_ready}, 16'd1);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].pp0);
      chk($sformatf("vec%0d_gidx_mid", i), {14'd0, bus.group_idx}, 16'd1);
      chk($sformatf("vec%0d_no_valid_mid", i), {15'd0, bus.out_valid}, 16'd0);
      send(vecs[i].pp1);
      chk($sformatf("vec%0d_out_valid", i), {15'd0, bus.out_valid}, 16'd1);
      chk($sformatf("vec%0d_product", i),   {8'd0, bus.product},    {8'd0, vecs[i].exp});
      chk($sformatf("vec%0d_pp_ready_done", i), {15'd0, bus.pp_ready}, 16'd0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk($sformatf("vec%0d_consumed", i), {15'd0, bus.out_valid}, 16'd0);
      chk($sformatf("vec%0d_gidx_idle", i), {14'd0, bus.group_idx}, 16'd0);
      chk($sformatf("vec%0d_product_kept", i), {8'd0, bus.product}, {8'd0, vecs[i].exp});
    end

    // out_ready held high: out_valid lasts exactly one cycle.
    bus.out_ready = 1'b1;
    send(6'h06);
    send(6'h3D);
    chk("basic_out_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("basic_product",   {8'd0, bus.product},    16'h00FA);
    step();
    chk("basic_one_cycle", {15'd0, bus.out_valid}, 16'd0);
    chk("basic_ready_back", {15'd0, bus.pp_ready}, 16'd1);
    bus.out_ready = 1'b0;

    // Backpressure for 5 cycles.
    send(6'h06);
    send(6'h3D);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_product", c),   {8'd0, bus.product},    16'h00FA);
      chk($sformatf("bp%0d_out_valid", c), {15'd0, bus.out_valid}, 16'd1);
      chk($sformatf("bp%0d_pp_ready", c),  {15'd0, bus.pp_ready},  16'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_release_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("bp_release_pp_ready",  {15'd0, bus.pp_ready},  16'd1);

    // Three idle cycles between the groups.
    send(6'h06);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("gap%0d_gidx", c), {14'd0, bus.group_idx}, 16'd1);
      step();
    end
    send(6'h3D);
    chk("gap_out_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("gap_product",   {8'd0, bus.product},    16'h00FA);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Flush in the cycle presenting group 1; that pp must be dropped.
    send(6'h32);
    bus.pp       = 6'h3D;
    bus.pp_valid = 1'b1;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.pp_valid = 1'b0;
    chk("flush_gidx",      {14'd0, bus.group_idx}, 16'd0);
    chk("flush_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("flush_pp_ready",  {15'd0, bus.pp_ready},  16'd1);
    send(6'h06);
    send(6'h3D);
    chk("post_flush_out_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("post_flush_product",   {8'd0, bus.product},    16'h00FA);

    // Flush while a product waits in DONE.
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_done_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("flush_done_pp_ready",  {15'd0, bus.pp_ready},  16'd1);

    // Asynchronous reset mid-accumulation, between clock edges.
    send(6'h06);
    chk("pre_reset_gidx", {14'd0, bus.group_idx}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gidx",      {14'd0, bus.group_idx}, 16'd0);
    chk("async_rst_pp_ready",  {15'd0, bus.pp_ready},  16'd0);
    chk("async_rst_product",   {8'd0, bus.product},    16'd0);
    chk("async_rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_pp_ready", {15'd0, bus.pp_ready}, 16'd1);
    send(6'h00);
    send(6'h10);
    chk("post_rst_product", {8'd0, bus.product}, 16'h0040);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
